freq_meter: RTL and testbench

Digital frequency counter that measures an asynchronous clock, such as a `vco` output, against the system clock. It counts rising edges of `meas_clk_i` over a fixed gate window of `clk_i` cycles and reports the count on a valid/ready output. It is the measuring counterpart to the VCO: the VCO turns a control word into a frequency, and this block turns a frequency back into a word for lock/trim controllers.

---
 rtl/freq_meter.sv | 120 ++++++++++++
 tb/tb_freq_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Frequency counter: counts synchronized rising edges of meas_clk_i over a
// fixed window of GATE_CYCLES clk_i cycles and publishes the count on valid/ready.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   meas_clk_i,
  input  logic                   enable_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   overflow_o,
  output logic                   overrun_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   pulse;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   ovf_q, ovf_d, sat_hit;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   overrun_q, overrun_d;
  logic                   valid_q, valid_d;

  // Returns {saturation_hit, saturated_sum}; the counter sticks at all-ones.
  function automatic logic [COUNT_WIDTH:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                   input logic inc);
    if (inc && (&a)) return {1'b1, a};
    return {1'b0, a + COUNT_WIDTH'(inc)};
  endfunction

  assign pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign {sat_hit, cnt_inc} = sat_add(cnt_q, pulse);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    overrun_d  = overrun_q;
    valid_d    = valid_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        if (enable_i) state_d = MEASURE;
      end
      MEASURE: begin
        if (timer_q == LAST) begin
          // Window end publishes regardless of enable; a pending, unaccepted result is overrun.
          count_d    = cnt_inc;
          overflow_d = ovf_q | sat_hit;
          overrun_d  = valid_q & ~ready_i;
          valid_d    = 1'b1;
          timer_d    = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          if (!enable_i) state_d = IDLE;
        end else if (!enable_i) begin
          state_d = IDLE;
          timer_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
          cnt_d   = cnt_inc;
          ovf_d   = ovf_q | sat_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      timer_q    <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], meas_clk_i};
      hist_q     <= sync_q[SYNC_STAGES-1];
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
      valid_q    <= valid_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign overrun_o  = overrun_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a result scoreboard; shortened gate
// window and narrow counter keep the run short and make saturation reachable.
module tb_freq_meter;

  localparam int G  = 200;
  localparam int CW = 6;

  logic          clk;
  logic          arst_ni;
  logic          meas_clk;
  logic          enable;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          overrun_o;
  logic          valid_o;
  logic          ready;

  int vectors;
  int miscompares;
  int meas_div;
  int meas_hi;
  bit meas_level;
  int drops;

  typedef struct {
    string tag;
    int    lo;
    int    hi;
    bit    ovf;
    bit    ovr;
  } exp_t;
  exp_t sb[$];

  freq_meter #(.GATE_CYCLES(G), .COUNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .arst_ni    (arst_ni),
    .meas_clk_i (meas_clk),
    .enable_i   (enable),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .overrun_o  (overrun_o),
    .valid_o    (valid_o),
    .ready_i    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Measured clock: meas_div clk periods per cycle, meas_hi of them high; 0 holds meas_level.
  initial begin
    int ph;
    ph = 0;
    meas_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (meas_div == 0) meas_clk = meas_level;
      else begin
        ph = (ph + 1) % meas_div;
        meas_clk = (ph < meas_hi);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    logic inr;
    inr = (obs >= lo) && (obs <= hi);
    vectors++;
    assert (inr === 1'b1)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic push(input string tag, input int lo, input int hi, input bit ovf, input bit ovr);
    exp_t e;
    e.tag = tag; e.lo = lo; e.hi = hi; e.ovf = ovf; e.ovr = ovr;
    sb.push_back(e);
  endtask

  // Waits (bounded) for valid_o, then compares against the oldest scoreboard entry.
  task automatic pop_check(input int budget, input int exp_wait);
    int   waited;
    exp_t e;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (valid_o !== 1'b1 && waited < budget);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_valid"}, 32'(valid_o), 32'd1);
    if (exp_wait >= 0) chk({e.tag, "_latency"}, 32'(waited), 32'(exp_wait));
    chk_rng({e.tag, "_count"}, 32'(count_o), e.lo, e.hi);
    chk({e.tag, "_overflow"}, 32'(overflow_o), 32'(e.ovf));
    chk({e.tag, "_overrun"}, 32'(overrun_o), 32'(e.ovr));
  endtask

  task automatic hold_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid_o !== 1'b1) drops++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; drops = 0;
    arst_ni = 1'b0; enable = 1'b0; ready = 1'b1;
    meas_div = 4; meas_hi = 2; meas_level = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    arst_ni = 1'b1;
    repeat (2) tick();
    chk("idle_valid", 32'(valid_o), 32'd0);

    // Continuous f/4 measurement, one-cycle valid pulses
    enable = 1'b1;
    push("t1a", 49, 51, 0, 0); pop_check(G + 5, G + 1);
    tick();
    chk("t1_pulse", 32'(valid_o), 32'd0);
    push("t1b", 49, 51, 0, 0); pop_check(G + 5, G - 1);
    push("t1c", 49, 51, 0, 0); pop_check(G + 5, G);

    // Held input, then a single step
    meas_div = 0; meas_level = 1'b0;
    push("t3_part", 0, 51, 0, 0); pop_check(G + 5, G);
    push("t3_zero", 0, 0, 0, 0);  pop_check(G + 5, G);
    meas_level = 1'b1;
    push("t3_step", 1, 1, 0, 0);  pop_check(G + 5, G);
    push("t3_high", 0, 0, 0, 0);  pop_check(G + 5, G);

    // Saturation at f/3, then recovery at f/10
    meas_div = 3; meas_hi = 2;
    push("t2_sat", 63, 63, 1, 0);  pop_check(G + 5, G);
    meas_div = 10; meas_hi = 5;
    push("t2_trans", 0, 62, 0, 0); pop_check(G + 5, G);
    push("t2_slow", 19, 21, 0, 0); pop_check(G + 5, G);

    // Backpressure: hold, overwrite, accept, then accept coinciding with window end
    meas_div = 4; meas_hi = 2;
    push("t4_trans", 0, 63, 0, 0); pop_check(G + 5, G);
    tick();
    ready = 1'b0;
    push("t4_r1", 49, 51, 0, 0); pop_check(G + 5, G - 1);
    drops = 0;
    hold_ticks(G - 1);
    push("t4_r2", 49, 51, 0, 1); pop_check(1, 1);
    hold_ticks(G / 2);
    chk("t4_valid_held", 32'(drops), 32'd0);
    ready = 1'b1;
    tick();
    chk("t4_accept_fall", 32'(valid_o), 32'd0);
    push("t4_r3", 49, 51, 0, 0); pop_check(G + 5, G - G / 2 - 1);
    tick();
    ready = 1'b0;
    push("t4_r4", 49, 51, 0, 0); pop_check(G + 5, G - 1);
    drops = 0;
    hold_ticks(G - 1);
    chk("t4_r4_held", 32'(drops), 32'd0);
    ready = 1'b1;
    push("t4_sim", 49, 51, 0, 0); pop_check(1, 1);
    tick();
    chk("t4_sim_fall", 32'(valid_o), 32'd0);

    // Enable dropped mid-window: pending result kept, no new result
    ready = 1'b0;
    push("t5_pend", 49, 51, 0, 0); pop_check(G + 5, G - 1);
    repeat (80) tick();
    enable = 1'b0;
    drops = 0;
    hold_ticks(G + 10);
    chk("t5_pend_held", 32'(drops), 32'd0);
    chk("t5_no_new_result", 32'(overrun_o), 32'd0);
    ready = 1'b1;
    tick();
    chk("t5_accept_fall", 32'(valid_o), 32'd0);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_o !== 1'b0) drops++;
    end
    chk("t5_idle_quiet", 32'(drops), 32'd0);
    enable = 1'b1;
    push("t5_re", 49, 51, 0, 0); pop_check(G + 5, G + 1);

    // Asynchronous reset with a pending result
    ready = 1'b0;
    repeat (100) tick();
    chk("t6_pending", 32'(valid_o), 32'd1);
    arst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid_o), 32'd0);
    chk("t6_rst_count", 32'(count_o), 32'd0);
    chk("t6_rst_overflow", 32'(overflow_o), 32'd0);
    chk("t6_rst_overrun", 32'(overrun_o), 32'd0);
    repeat (3) tick();
    arst_ni = 1'b1;
    ready = 1'b1;
    push("t6_post", 49, 51, 0, 0); pop_check(G + 5, G + 1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
